// File: rtl/readreg_bypass_pkg.sv
// Shared types and helpers for the readreg bypass stage.
// Operand record and feedback-channel priority match.
package readreg_bypass_pkg;

  localparam int SRC_NUM = 2;
  localparam int DATA_W  = 32;
  localparam int BYP_MAX = 16;

  typedef struct packed {
    logic              loaded;
    logic [DATA_W-1:0] value;
  } operand_t;

  // True when channel k is the lowest-index hit.
  function automatic logic byp_match(
    input logic [BYP_MAX-1:0] hit,
    input int unsigned        k
  );
    logic [BYP_MAX-1:0] lower;
    lower = (BYP_MAX'(1) << k) - BYP_MAX'(1);
    return hit[k] && ((hit & lower) == '0);
  endfunction

endpackage

// File: rtl/readreg_bypass_stage_if.sv
// Rename-facing, register-file, feedback and issue-facing signals
// of the readreg bypass stage.
interface readreg_bypass_stage_if #(
  parameter int WIDTH            = 2,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int BYPASS_CH        = 4,
  parameter int PAYLOAD_WIDTH    = 64,
  parameter int PERF_CNT_WIDTH   = 32
);

  localparam int NOP = WIDTH * 2;

  logic [WIDTH-1:0]                    in_valid;
  logic [NOP-1:0]                      in_rs_need;
  logic [NOP*PHY_REG_ID_WIDTH-1:0]     in_rs_phy;
  logic [WIDTH*PAYLOAD_WIDTH-1:0]      in_payload;
  logic                                in_ready;
  logic [NOP*PHY_REG_ID_WIDTH-1:0]     phyf_id;
  logic [NOP*REG_DATA_WIDTH-1:0]       phyf_data;
  logic [NOP-1:0]                      phyf_data_valid;
  logic [BYPASS_CH-1:0]                byp_en;
  logic [BYPASS_CH*PHY_REG_ID_WIDTH-1:0] byp_phy_id;
  logic [BYPASS_CH*REG_DATA_WIDTH-1:0] byp_value;
  logic                                flush;
  logic [WIDTH-1:0]                    out_valid;
  logic [NOP-1:0]                      out_src_loaded;
  logic [NOP*REG_DATA_WIDTH-1:0]       out_src_value;
  logic [WIDTH*PAYLOAD_WIDTH-1:0]      out_payload;
  logic                                out_ready;
  logic [PERF_CNT_WIDTH-1:0]           perf_stall_cnt;

  modport master (
    output in_valid, in_rs_need, in_rs_phy, in_payload,
    output phyf_data, phyf_data_valid,
    output byp_en, byp_phy_id, byp_value,
    output flush, out_ready,
    input  in_ready, phyf_id,
    input  out_valid, out_src_loaded, out_src_value,
    input  out_payload, perf_stall_cnt
  );

  modport slave (
    input  in_valid, in_rs_need, in_rs_phy, in_payload,
    input  phyf_data, phyf_data_valid,
    input  byp_en, byp_phy_id, byp_value,
    input  flush, out_ready,
    output in_ready, phyf_id,
    output out_valid, out_src_loaded, out_src_value,
    output out_payload, perf_stall_cnt
  );

endinterface

// File: rtl/readreg_operand_sel.sv
// One source operand: feedback channels first, then the
// register file when enabled, else left unloaded.
module readreg_operand_sel
  import readreg_bypass_pkg::*;
#(
  parameter int ID_W = 6,
  parameter int CH   = 4
) (
  input  logic                 i_need,
  input  logic [ID_W-1:0]      i_phy,
  input  logic                 i_use_phyf,
  input  logic [DATA_W-1:0]    i_phyf_data,
  input  logic                 i_phyf_valid,
  input  logic [CH-1:0]        i_byp_en,
  input  logic [CH*ID_W-1:0]   i_byp_id,
  input  logic [CH*DATA_W-1:0] i_byp_value,
  output operand_t             o_opnd
);

  logic [BYP_MAX-1:0] w_hit;
  logic [DATA_W-1:0]  w_byp_val;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < CH; k++) begin
      w_hit[k] = i_byp_en[k] &&
                 (i_byp_id[k*ID_W +: ID_W] == i_phy);
    end
  end

  always_comb begin
    w_byp_val = '0;
    for (int k = 0; k < CH; k++) begin
      if (byp_match(w_hit, k)) begin
        w_byp_val = i_byp_value[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    o_opnd = '0;
    if (!i_need) begin
      o_opnd.loaded = 1'b1;
    end else if (|w_hit) begin
      o_opnd.loaded = 1'b1;
      o_opnd.value  = w_byp_val;
    end else if (i_use_phyf && i_phyf_valid) begin
      o_opnd.loaded = 1'b1;
      o_opnd.value  = i_phyf_data;
    end
  end

endmodule

// File: rtl/readreg_bypass_stage.sv
// Rename-to-issue operand read stage; a held group keeps
// snooping feedback channels for operands still missing.
module readreg_bypass_stage
  import readreg_bypass_pkg::*;
#(
  parameter int WIDTH            = 2,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int REG_DATA_WIDTH   = DATA_W,
  parameter int BYPASS_CH        = 4,
  parameter int PAYLOAD_WIDTH    = 64,
  parameter int PERF_CNT_WIDTH   = 32
) (
  input  logic clk,
  input  logic rst,
  readreg_bypass_stage_if.slave bus
);

  localparam int NOP = WIDTH * SRC_NUM;
  localparam int IDW = PHY_REG_ID_WIDTH;
  localparam int DW  = REG_DATA_WIDTH;

  logic w_in_ready;
  logic w_fire_out;
  logic w_accept;
  logic w_hold;

  operand_t w_sel [NOP];
  operand_t w_cap [NOP];

  logic [NOP-1:0]     w_loaded;
  logic [NOP*DW-1:0]  w_value;

  logic                           r_occ;
  logic [WIDTH-1:0]               r_out_valid;
  operand_t                       r_src [NOP];
  logic [IDW-1:0]                 r_phy [NOP];
  logic [WIDTH*PAYLOAD_WIDTH-1:0] r_payload;
  logic [PERF_CNT_WIDTH-1:0]      r_stall_cnt;

  assign w_in_ready = ~r_occ | bus.out_ready;
  assign w_fire_out = r_occ & bus.out_ready;
  assign w_hold     = r_occ & ~bus.out_ready;
  assign w_accept   = w_in_ready & (|bus.in_valid) & ~bus.flush;

  assign bus.in_ready = w_in_ready;
  assign bus.phyf_id  = bus.in_rs_phy;

  for (genvar g = 0; g < NOP; g++) begin : g_opnd
    readreg_operand_sel #(
      .ID_W (IDW),
      .CH   (BYPASS_CH)
    ) u_acc (
      .i_need       (bus.in_rs_need[g]),
      .i_phy        (bus.in_rs_phy[g*IDW +: IDW]),
      .i_use_phyf   (1'b1),
      .i_phyf_data  (bus.phyf_data[g*DW +: DW]),
      .i_phyf_valid (bus.phyf_data_valid[g]),
      .i_byp_en     (bus.byp_en),
      .i_byp_id     (bus.byp_phy_id),
      .i_byp_value  (bus.byp_value),
      .o_opnd       (w_sel[g])
    );

    // Held operands only listen to feedback channels.
    readreg_operand_sel #(
      .ID_W (IDW),
      .CH   (BYPASS_CH)
    ) u_cap (
      .i_need       (1'b1),
      .i_phy        (r_phy[g]),
      .i_use_phyf   (1'b0),
      .i_phyf_data  ('0),
      .i_phyf_valid (1'b0),
      .i_byp_en     (bus.byp_en),
      .i_byp_id     (bus.byp_phy_id),
      .i_byp_value  (bus.byp_value),
      .o_opnd       (w_cap[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ       <= 1'b0;
      r_out_valid <= '0;
      r_payload   <= '0;
      for (int i = 0; i < NOP; i++) begin
        r_src[i] <= '0;
        r_phy[i] <= '0;
      end
    end else if (bus.flush) begin
      r_occ       <= 1'b0;
      r_out_valid <= '0;
    end else if (w_accept) begin
      r_occ       <= 1'b1;
      r_out_valid <= bus.in_valid;
      r_payload   <= bus.in_payload;
      for (int i = 0; i < NOP; i++) begin
        r_src[i] <= w_sel[i];
        r_phy[i] <= bus.in_rs_phy[i*IDW +: IDW];
      end
    end else if (w_fire_out) begin
      r_occ       <= 1'b0;
      r_out_valid <= '0;
    end else if (r_occ) begin
      for (int i = 0; i < NOP; i++) begin
        if (!r_src[i].loaded) begin
          r_src[i] <= w_cap[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_hold && !bus.flush && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + PERF_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_loaded = '0;
    w_value  = '0;
    for (int i = 0; i < NOP; i++) begin
      w_loaded[i]          = r_src[i].loaded;
      w_value[i*DW +: DW]  = r_src[i].value;
    end
  end

  assign bus.out_valid      = r_out_valid;
  assign bus.out_src_loaded = w_loaded;
  assign bus.out_src_value  = w_value;
  assign bus.out_payload    = r_payload;
  assign bus.perf_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_readreg_bypass_stage.sv
// Scoreboard bench for readreg_bypass_stage: accept, bypass
// priority, stall capture, flush and async reset.
module tb_readreg_bypass_stage;

  typedef struct {
    logic [1:0]   v;
    logic [3:0]   l;
    logic [127:0] d;
    logic [127:0] p;
  } exp_t;

  localparam logic [23:0]  PHY = {6'd4, 6'd2, 6'd3, 6'd1};
  localparam logic [127:0] PF  = {32'hcdea1578, 32'hcdea1576,
                                  32'hcdea1577, 32'hcdea1575};

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb [$];

  readreg_bypass_stage_if bus ();

  readreg_bypass_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [3:0] l,
                      input logic [127:0] d, input logic [127:0] p);
    exp_t e;
    e.v = v;
    e.l = l;
    e.d = d;
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'(0), 128'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'(e.v));
      chk({tag, "_loaded"}, 128'(bus.out_src_loaded), 128'(e.l));
      chk({tag, "_value"}, bus.out_src_value, e.d);
      chk({tag, "_payload"}, bus.out_payload, e.p);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pay;
    n_cmp = 0;
    n_bad = 0;
    clk = 1'b0;
    rst = 1'b0;
    bus.in_valid        = '0;
    bus.in_rs_need      = '0;
    bus.in_rs_phy       = '0;
    bus.in_payload      = '0;
    bus.phyf_data       = '0;
    bus.phyf_data_valid = '0;
    bus.byp_en          = '0;
    bus.byp_phy_id      = '0;
    bus.byp_value       = '0;
    bus.flush           = 1'b0;
    bus.out_ready       = 1'b1;

    // 1: reset
    #23;
    chk("rst_held_valid", 128'(bus.out_valid), 128'(0));
    rst = 1'b1;
    tick();
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_perf", 128'(bus.perf_stall_cnt), 128'(0));

    // 2: everything from the register file
    pay = {64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    bus.in_valid        = 2'b11;
    bus.in_rs_need      = 4'b1111;
    bus.in_rs_phy       = PHY;
    bus.in_payload      = pay;
    bus.phyf_data       = PF;
    bus.phyf_data_valid = 4'b1111;
    #1;
    chk("s2_phyf_id", 128'(bus.phyf_id), 128'(PHY));
    push(2'b11, 4'b1111, PF, pay);
    tick();
    check_out("s2");

    // 3: back-to-back, ch0 beats ch2 and the register file
    pay = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003};
    bus.in_payload = pay;
    bus.byp_en     = 4'b0101;
    bus.byp_phy_id = {6'd0, 6'd1, 6'd0, 6'd1};
    bus.byp_value  = {32'h0, 32'h4a5cddef, 32'h0, 32'hacde1285};
    push(2'b11, 4'b1111,
         {PF[127:32], 32'hacde1285}, pay);
    tick();
    check_out("s3");

    // 4: accept unloaded, then late capture while stalled
    pay = {64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005};
    bus.in_payload      = pay;
    bus.byp_en          = '0;
    bus.phyf_data_valid = '0;
    push(2'b11, 4'b0000, 128'(0), pay);
    tick();
    check_out("s4_acc");
    bus.in_valid        = '0;
    bus.out_ready       = 1'b0;
    bus.phyf_data_valid = 4'b1111;
    tick();
    chk("s4_perf1", 128'(bus.perf_stall_cnt), 128'(1));
    chk("s4_no_phyf", 128'(bus.out_src_loaded), 128'(0));
    bus.byp_en     = 4'b1000;
    bus.byp_phy_id = {6'd4, 18'd0};
    bus.byp_value  = {32'h1234, 96'd0};
    push(2'b11, 4'b1000, {32'h1234, 96'd0}, pay);
    tick();
    check_out("s4_cap");
    bus.byp_en = '0;
    push(2'b11, 4'b1000, {32'h1234, 96'd0}, pay);
    tick();
    check_out("s4_hold");
    chk("s4_perf3", 128'(bus.perf_stall_cnt), 128'(3));

    // 5: flush while stalled, then flush with out_ready
    bus.in_valid   = 2'b11;
    bus.flush      = 1'b1;
    bus.byp_en     = 4'b0001;
    bus.byp_phy_id = {18'd0, 6'd1};
    bus.byp_value  = {96'd0, 32'h5555};
    #1;
    chk("s5_in_ready0", 128'(bus.in_ready), 128'(0));
    tick();
    chk("s5_valid", 128'(bus.out_valid), 128'(0));
    chk("s5_no_cap", 128'(bus.out_src_loaded), 128'(4'b1000));
    chk("s5_perf", 128'(bus.perf_stall_cnt), 128'(3));
    bus.byp_en    = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("s5_in_ready1", 128'(bus.in_ready), 128'(1));
    tick();
    chk("s5_no_acc_v", 128'(bus.out_valid), 128'(0));
    chk("s5_no_acc_l", 128'(bus.out_src_loaded), 128'(4'b1000));
    chk("s5_no_acc_d", bus.out_src_value, {32'h1234, 96'd0});

    // 6: single-lane group, stall, then async reset
    pay = {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007};
    bus.flush      = 1'b0;
    bus.in_valid   = 2'b01;
    bus.in_payload = pay;
    push(2'b01, 4'b1111, PF, pay);
    tick();
    check_out("s6_acc");
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("s6_perf5", 128'(bus.perf_stall_cnt), 128'(5));
    #2;
    rst = 1'b0;
    #1;
    chk("s6_rst_valid", 128'(bus.out_valid), 128'(0));
    chk("s6_rst_perf", 128'(bus.perf_stall_cnt), 128'(0));
    chk("s6_rst_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("s6_after", 128'(bus.out_valid), 128'(0));
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/readreg_bypass_stage.md
Name: readreg_bypass_stage

Overview:
- Parametrised successor of the readreg stage in the out-of-order RISC-V core. Sits between rename and issue.
- Accepts a group of up to WIDTH ops and issues physical register-file reads for both source operands of each op.
- Resolves each operand from BYPASS_CH feedback channels (execute and wb channels, concatenated) or from the register file.
- Holds the group in an output register. While issue stalls, still-unloaded operands keep snooping the feedback channels and capture late-arriving values.

Parameters:
WIDTH, 2, ops per group (lanes)
PHY_REG_ID_WIDTH, 6, physical register id width
REG_DATA_WIDTH, 32, register data width
BYPASS_CH, 4, feedback channels; lower index = higher priority
PAYLOAD_WIDTH, 64, opaque per-op payload passed through unchanged
PERF_CNT_WIDTH, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  WIDTH  lane valid from rename
in_rs_need  in  WIDTH*2  operand j of lane i needs a register (bit i*2+j)
in_rs_phy  in  WIDTH*2*PHY_REG_ID_WIDTH  operand physical ids
in_payload  in  WIDTH*PAYLOAD_WIDTH  op payload
in_ready  out  1  group accepted this cycle when in_ready and any in_valid
phyf_id  out  WIDTH*2*PHY_REG_ID_WIDTH  register-file read ids, equal to in_rs_phy (combinational)
phyf_data  in  WIDTH*2*REG_DATA_WIDTH  register-file read data
phyf_data_valid  in  WIDTH*2  register-file value ready
byp_en  in  BYPASS_CH  feedback channel valid
byp_phy_id  in  BYPASS_CH*PHY_REG_ID_WIDTH  feedback destination id
byp_value  in  BYPASS_CH*REG_DATA_WIDTH  feedback value
flush  in  1  pipeline flush from commit
out_valid  out  WIDTH  lane valid to issue
out_src_loaded  out  WIDTH*2  operand value present
out_src_value  out  WIDTH*2*REG_DATA_WIDTH  operand value
out_payload  out  WIDTH*PAYLOAD_WIDTH  registered payload
out_ready  in  1  issue not stalled
perf_stall_cnt  out  PERF_CNT_WIDTH  count of cycles where occ=1 and out_ready=0, saturating

Behaviour:
- Reset (rst=0, async): occ=0; all out_* registers=0; perf_stall_cnt=0. in_ready=1 after release.
- State: occ (group held) plus per-lane/per-operand registers.
- Handshakes:
  - fire_out = occ & out_ready.
  - in_ready = ~occ | out_ready (combinational, independent of flush).
  - accept = in_ready & |in_valid & ~flush.
- Operand select, combinational, per operand:
  - need=0: loaded=1, value=0.
  - Else the lowest-index channel k with byp_en[k] and byp_phy_id[k]==phy gives loaded=1, value=byp_value[k].
  - Else, if phyf_data_valid: loaded=1, value=phyf_data.
  - Else loaded=0, value=0.
  - Bypass beats the register file.
- Edge update, in priority order:
  1. flush: occ<=0 and out_valid<=0, regardless of accept or out_ready. Data registers keep their values.
  2. accept: load the group. occ<=1, out_valid<=in_valid, loaded/value from select, payload latched. Latency 1 cycle. Back-to-back accept while out_ready=1 gives one group per cycle.
  3. fire_out without accept: occ<=0, out_valid<=0.
  4. Held (occ & ~out_ready): each operand with loaded=0 is matched against the bypass channels only, not the register file. On a hit, set loaded=1 and value=byp_value using the same priority. Loaded operands never change.
- Invalid lanes: out_valid=0. Their loaded/value fields are don't-care but deterministic (computed by the select rule).
- perf_stall_cnt increments when occ & ~out_ready and flush=0. It saturates at all-ones and clears only on reset.
- Reset asserted mid-stall drops the held group immediately.

Decomposition:
- Package readreg_bypass_pkg holds:
  - operand_t struct {loaded, value}
  - function byp_match (priority encode over channels)
  - localparam SRC_NUM=2
- Sub-module readreg_operand_sel: one operand's bypass/register-file priority mux with a use_phyf enable input. Instantiated 2*WIDTH times for the accept path; the capture path calls it with use_phyf=0.

Test Plan:
All scenarios use defaults WIDTH=2, BYPASS_CH=4.
1. Reset with rst=0 and out_ready=1, then release -> in_ready=1, out_valid=00, perf_stall_cnt=0.
2. in_valid=11, phys {1,3},{2,4}, all phyf_data_valid=1, phyf_data=id+0xcdea1574, byp_en=0 -> next cycle all loaded=1, values 0xcdea1575/0xcdea1577/0xcdea1576/0xcdea1578.
3. Same as scenario 2, plus byp ch0 id=1 value 0xacde1285 and ch2 id=1 value 0x4a5cddef -> lane0 src0 = 0xacde1285 (lowest channel wins over both the register file and ch2).
4. Accept a group with phyf_data_valid=0 and byp_en=0, then hold out_ready=0 for 3 cycles with ch3 id=4 value 0x1234 in cycle 2 -> lane1 src1 loaded=1 with 0x1234 from cycle 3; other operands stay 0; perf_stall_cnt=3.
5. occ=1, out_ready=0, in_valid=11, flush=1 -> in_ready=0, next out_valid=00 and no capture. A later flush=1 with out_ready=1 and in_valid=11 -> in_ready=1, but the group is not accepted and out_valid=00.
6. Pulse rst low mid-stall with occ=1 -> out_valid=00 and counter=0 immediately, without waiting for a clock edge.
